// File: rtl/ttt_pkg.sv
// Shared definitions for the token-timing channels: channel state and default widths.
package ttt_pkg;

  localparam int unsigned DEF_N_CHANNELS      = 4;
  localparam int unsigned DEF_NEW_TOKENS_BITS = 4;
  localparam int unsigned DEF_TOKENS_BITS     = 8;
  localparam int unsigned DEF_DURATION_BITS   = 4;

  typedef enum logic {
    IDLE = 1'b0,
    ON   = 1'b1
  } chan_state_e;

endpackage

// File: rtl/ttt_channel.sv
// One token channel: saturating good/bad accumulators, IDLE/ON state and an
// optional tick-driven timeout that ends the token.
module ttt_channel
  import ttt_pkg::*;
#(
  parameter int unsigned NEW_TOKENS_BITS = DEF_NEW_TOKENS_BITS,
  parameter int unsigned TOKENS_BITS     = DEF_TOKENS_BITS,
  parameter int unsigned DURATION_BITS   = DEF_DURATION_BITS
) (
  input  logic                              clock_fast,
  input  logic                              reset,
  input  logic                              tick_i,
  input  logic signed [NEW_TOKENS_BITS-1:0] new_good_tokens_i,
  input  logic signed [NEW_TOKENS_BITS-1:0] new_bad_tokens_i,
  input  logic        [TOKENS_BITS-1:0]     good_tokens_threshold_i,
  input  logic        [TOKENS_BITS-1:0]     bad_tokens_threshold_i,
  input  logic        [DURATION_BITS-1:0]   duration_i,
  input  logic                              clear_on_end_i,
  output logic                              token_start_o,
  output logic                              token_end_o,
  output logic                              is_on_o
);

  localparam logic signed [TOKENS_BITS-1:0] ACC_MAX = {1'b0, {(TOKENS_BITS-1){1'b1}}};
  localparam logic signed [TOKENS_BITS-1:0] ACC_MIN = {1'b1, {(TOKENS_BITS-1){1'b0}}};

  // Add a sign-extended increment, clamping to the signed accumulator range.
  function automatic logic signed [TOKENS_BITS-1:0] sat_add(
    input logic signed [TOKENS_BITS-1:0]     acc,
    input logic signed [NEW_TOKENS_BITS-1:0] inc
  );
    logic signed [TOKENS_BITS:0]   sum;
    logic signed [TOKENS_BITS-1:0] res;
    sum = {acc[TOKENS_BITS-1], acc}
        + {{(TOKENS_BITS+1-NEW_TOKENS_BITS){inc[NEW_TOKENS_BITS-1]}}, inc};
    if (sum[TOKENS_BITS] != sum[TOKENS_BITS-1]) begin
      res = sum[TOKENS_BITS] ? ACC_MIN : ACC_MAX;
    end else begin
      res = sum[TOKENS_BITS-1:0];
    end
    return res;
  endfunction

  // Negate an unsigned threshold; thresholds beyond the negative range clamp to the minimum.
  function automatic logic signed [TOKENS_BITS-1:0] neg_sat(
    input logic [TOKENS_BITS-1:0] thr
  );
    logic signed [TOKENS_BITS:0]   n;
    logic signed [TOKENS_BITS-1:0] res;
    n = '0 - {1'b0, thr};
    if (n[TOKENS_BITS] != n[TOKENS_BITS-1]) begin
      res = ACC_MIN;
    end else begin
      res = n[TOKENS_BITS-1:0];
    end
    return res;
  endfunction

  chan_state_e                     state_q;
  logic signed [TOKENS_BITS-1:0]   good_q, good_d;
  logic signed [TOKENS_BITS-1:0]   bad_q, bad_d;
  logic signed [TOKENS_BITS-1:0]   good_reload_q, good_reload_d;
  logic signed [TOKENS_BITS-1:0]   bad_reload_q, bad_reload_d;
  logic        [DURATION_BITS-1:0] timer_q;
  logic                            timed_q;
  logic                            token_start_q;
  logic                            token_end_q;
  logic                            good_nonneg;
  logic                            bad_nonpos;
  logic                            bad_pos;

  // Next accumulator values, re-arm values and sign decisions on the registered accumulators.
  always_comb begin
    good_d        = sat_add(good_q, new_good_tokens_i);
    bad_d         = sat_add(bad_q, new_bad_tokens_i);
    good_reload_d = neg_sat(good_tokens_threshold_i);
    bad_reload_d  = neg_sat(bad_tokens_threshold_i);
    good_nonneg   = ~good_q[TOKENS_BITS-1];
    bad_pos       = ~bad_q[TOKENS_BITS-1] && (bad_q != '0);
    bad_nonpos    = ~bad_pos;
  end

  // Channel FSM with accumulators, timer and registered start/end pulses.
  // Thresholds are captured at reset so later threshold changes only matter after the next reset.
  always_ff @(posedge clock_fast) begin
    if (reset) begin
      state_q       <= IDLE;
      good_q        <= good_reload_d;
      bad_q         <= bad_reload_d;
      good_reload_q <= good_reload_d;
      bad_reload_q  <= bad_reload_d;
      timer_q       <= '0;
      timed_q       <= 1'b0;
      token_start_q <= 1'b0;
      token_end_q   <= 1'b0;
    end else begin
      token_start_q <= 1'b0;
      token_end_q   <= 1'b0;
      good_q        <= good_d;
      bad_q         <= bad_d;
      case (state_q)
        IDLE: begin
          if (good_nonneg && bad_nonpos) begin
            state_q       <= ON;
            token_start_q <= 1'b1;
            timer_q       <= duration_i;
            timed_q       <= (duration_i != '0);
          end
        end
        ON: begin
          if (bad_pos || (timed_q && (timer_q == '0))) begin
            state_q     <= IDLE;
            token_end_q <= 1'b1;
            if (clear_on_end_i) begin
              good_q <= good_reload_q;
              bad_q  <= bad_reload_q;
            end
          end else if (tick_i && (timer_q != '0)) begin
            timer_q <= timer_q - DURATION_BITS'(1);
          end
        end
      endcase
    end
  end

  assign token_start_o = token_start_q;
  assign token_end_o   = token_end_q;
  assign is_on_o       = (state_q == ON);

endmodule

// File: rtl/tt_um_jleugeri_ttt_multi_core.sv
// Array of independent token channels; slices the packed buses per channel.
module tt_um_jleugeri_ttt_multi_core
  import ttt_pkg::*;
#(
  parameter int unsigned N_CHANNELS      = DEF_N_CHANNELS,
  parameter int unsigned NEW_TOKENS_BITS = DEF_NEW_TOKENS_BITS,
  parameter int unsigned TOKENS_BITS     = DEF_TOKENS_BITS,
  parameter int unsigned DURATION_BITS   = DEF_DURATION_BITS
) (
  input  logic                                  clock_fast,
  input  logic                                  reset,
  input  logic                                  tick,
  input  logic [N_CHANNELS*NEW_TOKENS_BITS-1:0] new_good_tokens,
  input  logic [N_CHANNELS*NEW_TOKENS_BITS-1:0] new_bad_tokens,
  input  logic [N_CHANNELS*TOKENS_BITS-1:0]     good_tokens_threshold,
  input  logic [N_CHANNELS*TOKENS_BITS-1:0]     bad_tokens_threshold,
  input  logic [N_CHANNELS*DURATION_BITS-1:0]   duration,
  input  logic [N_CHANNELS-1:0]                 clear_on_end,
  output logic [N_CHANNELS-1:0]                 token_start,
  output logic [N_CHANNELS-1:0]                 token_end,
  output logic [N_CHANNELS-1:0]                 is_on
);

  for (genvar i = 0; i < N_CHANNELS; i++) begin : g_ch
    ttt_channel #(
      .NEW_TOKENS_BITS(NEW_TOKENS_BITS),
      .TOKENS_BITS    (TOKENS_BITS),
      .DURATION_BITS  (DURATION_BITS)
    ) u_channel (
      .clock_fast             (clock_fast),
      .reset                  (reset),
      .tick_i                 (tick),
      .new_good_tokens_i      (new_good_tokens[i*NEW_TOKENS_BITS +: NEW_TOKENS_BITS]),
      .new_bad_tokens_i       (new_bad_tokens[i*NEW_TOKENS_BITS +: NEW_TOKENS_BITS]),
      .good_tokens_threshold_i(good_tokens_threshold[i*TOKENS_BITS +: TOKENS_BITS]),
      .bad_tokens_threshold_i (bad_tokens_threshold[i*TOKENS_BITS +: TOKENS_BITS]),
      .duration_i             (duration[i*DURATION_BITS +: DURATION_BITS]),
      .clear_on_end_i         (clear_on_end[i]),
      .token_start_o          (token_start[i]),
      .token_end_o            (token_end[i]),
      .is_on_o                (is_on[i])
    );
  end

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_multi_core.sv
// Directed scenarios followed by randomized traffic, checked every cycle against a
// behavioural per-channel token model.
module tb_tt_um_jleugeri_ttt_multi_core;

  localparam int N  = 4;
  localparam int NB = 4;
  localparam int TB = 8;
  localparam int DB = 4;

  logic              clock_fast = 1'b0;
  logic              reset;
  logic              tick;
  logic [N*NB-1:0]   new_good_tokens;
  logic [N*NB-1:0]   new_bad_tokens;
  logic [N*TB-1:0]   good_tokens_threshold;
  logic [N*TB-1:0]   bad_tokens_threshold;
  logic [N*DB-1:0]   duration;
  logic [N-1:0]      clear_on_end;
  logic [N-1:0]      token_start;
  logic [N-1:0]      token_end;
  logic [N-1:0]      is_on;

  int n_cmp = 0;
  int n_bad = 0;

  int       mg[N], mb[N], mgr[N], mbr[N], mtimer[N];
  bit       mon[N], mtimed[N];
  logic [N-1:0] exp_st, exp_en, exp_on;

  tt_um_jleugeri_ttt_multi_core #(
    .N_CHANNELS     (N),
    .NEW_TOKENS_BITS(NB),
    .TOKENS_BITS    (TB),
    .DURATION_BITS  (DB)
  ) dut (
    .clock_fast           (clock_fast),
    .reset                (reset),
    .tick                 (tick),
    .new_good_tokens      (new_good_tokens),
    .new_bad_tokens       (new_bad_tokens),
    .good_tokens_threshold(good_tokens_threshold),
    .bad_tokens_threshold (bad_tokens_threshold),
    .duration             (duration),
    .clear_on_end         (clear_on_end),
    .token_start          (token_start),
    .token_end            (token_end),
    .is_on                (is_on)
  );

  always #5 clock_fast = ~clock_fast;

  function automatic int sat(input int v);
    int hi, lo;
    hi = (1 << (TB - 1)) - 1;
    lo = -(1 << (TB - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic int inc_of(input logic [N*NB-1:0] bus, input int ch);
    logic signed [NB-1:0] s;
    s = bus[ch*NB +: NB];
    return int'(s);
  endfunction

  // Reference behaviour for one clock edge, using the values present before the edge.
  task automatic model_step();
    for (int ch = 0; ch < N; ch++) begin
      int ng, nb, dur;
      dur = int'(duration[ch*DB +: DB]);
      if (reset) begin
        mgr[ch]    = sat(-int'(good_tokens_threshold[ch*TB +: TB]));
        mbr[ch]    = sat(-int'(bad_tokens_threshold[ch*TB +: TB]));
        mg[ch]     = mgr[ch];
        mb[ch]     = mbr[ch];
        mon[ch]    = 1'b0;
        mtimer[ch] = 0;
        mtimed[ch] = 1'b0;
        exp_st[ch] = 1'b0;
        exp_en[ch] = 1'b0;
      end else begin
        exp_st[ch] = 1'b0;
        exp_en[ch] = 1'b0;
        ng = sat(mg[ch] + inc_of(new_good_tokens, ch));
        nb = sat(mb[ch] + inc_of(new_bad_tokens, ch));
        if (!mon[ch]) begin
          if (mg[ch] >= 0 && mb[ch] <= 0) begin
            mon[ch]    = 1'b1;
            exp_st[ch] = 1'b1;
            mtimer[ch] = dur;
            mtimed[ch] = (dur != 0);
          end
        end else if (mb[ch] > 0 || (mtimed[ch] && mtimer[ch] == 0)) begin
          mon[ch]    = 1'b0;
          exp_en[ch] = 1'b1;
          if (clear_on_end[ch]) begin
            ng = mgr[ch];
            nb = mbr[ch];
          end
        end else if (tick && mtimer[ch] > 0) begin
          mtimer[ch] = mtimer[ch] - 1;
        end
        mg[ch] = ng;
        mb[ch] = nb;
      end
      exp_on[ch] = mon[ch];
    end
  endtask

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock: update the model at the edge, then sample outputs 1 time unit later.
  task automatic cycle();
    @(posedge clock_fast);
    model_step();
    #1;
    chk("model_token_start", token_start, exp_st);
    chk("model_token_end", token_end, exp_en);
    chk("model_is_on", is_on, exp_on);
  endtask

  task automatic set_ng(input int ch, input int v);
    new_good_tokens[ch*NB +: NB] = NB'(v);
  endtask

  task automatic set_nb(input int ch, input int v);
    new_bad_tokens[ch*NB +: NB] = NB'(v);
  endtask

  initial begin
    reset           = 1'b1;
    tick            = 1'b0;
    new_good_tokens = '0;
    new_bad_tokens  = '0;
    duration        = '0;
    clear_on_end    = '0;
    for (int ch = 0; ch < N; ch++) begin
      good_tokens_threshold[ch*TB +: TB] = TB'((ch == 0) ? 3 : 5);
      bad_tokens_threshold[ch*TB +: TB]  = TB'((ch == 0) ? 2 : 1);
    end
    cycle();
    cycle();
    chk("reset_is_on", is_on, '0);
    chk("reset_token_start", token_start, '0);
    chk("reset_token_end", token_end, '0);
    reset = 1'b0;

    // Good accumulator climbs from -3 to 0; start follows one cycle later.
    set_ng(0, 1);
    repeat (3) cycle();
    set_ng(0, 0);
    chk1("start_not_early", token_start[0], 1'b0);
    cycle();
    chk1("untimed_start", token_start[0], 1'b1);
    chk1("untimed_on", is_on[0], 1'b1);
    repeat (4) cycle();
    chk1("untimed_hold_on", is_on[0], 1'b1);
    chk1("start_is_pulse", token_start[0], 1'b0);

    // Bad goes positive and ends the untimed token.
    set_nb(0, 3);
    cycle();
    set_nb(0, 0);
    cycle();
    chk1("bad_end", token_end[0], 1'b1);
    chk1("bad_end_off", is_on[0], 1'b0);

    // Timed token, duration 3, tick every cycle (including the start edge).
    set_nb(0, -1);
    duration[0 +: DB] = DB'(3);
    tick = 1'b1;
    cycle();
    set_nb(0, 0);
    cycle();
    chk1("timed3_start", token_start[0], 1'b1);
    duration[0 +: DB] = DB'(2);
    repeat (3) cycle();
    chk1("timed3_no_early_end", token_end[0], 1'b0);
    cycle();
    chk1("timed3_end", token_end[0], 1'b1);
    chk1("timed3_off", is_on[0], 1'b0);

    // Restart with duration 2 while tick is high on the start edge.
    cycle();
    chk1("timed2_start", token_start[0], 1'b1);
    repeat (2) cycle();
    chk1("timed2_load_wins", token_end[0], 1'b0);
    cycle();
    chk1("timed2_end", token_end[0], 1'b1);
    tick = 1'b0;
    duration[0 +: DB] = '0;
    cycle();
    chk1("untimed_restart", token_start[0], 1'b1);

    // Clear on end: accumulators re-arm to -3/-2, no immediate restart.
    clear_on_end[0] = 1'b1;
    set_nb(0, 3);
    cycle();
    set_nb(0, 0);
    cycle();
    chk1("clear_end", token_end[0], 1'b1);
    repeat (3) cycle();
    chk1("clear_no_restart_on", is_on[0], 1'b0);
    chk1("clear_no_restart_start", token_start[0], 1'b0);

    // Saturation: good -3 -> 120 -> +21 clamps at 127; bad held positive meanwhile.
    set_nb(0, 7);
    set_ng(0, 7);
    repeat (17) cycle();
    set_ng(0, 4);
    cycle();
    set_ng(0, 7);
    repeat (3) cycle();
    set_ng(0, -1);
    set_nb(0, -8);
    cycle();
    set_ng(0, 0);
    repeat (15) cycle();
    set_nb(0, 0);
    cycle();
    chk1("saturated_good_start", token_start[0], 1'b1);

    // Channel 1 goes ON, then reset in the middle of both tokens.
    set_ng(1, 5);
    cycle();
    set_ng(1, 0);
    cycle();
    chk1("ch1_start", token_start[1], 1'b1);
    cycle();
    chk("both_on_before_reset", is_on, 4'b0011);
    reset = 1'b1;
    cycle();
    chk("mid_reset_no_end", token_end, '0);
    chk("mid_reset_is_on", is_on, '0);
    reset = 1'b0;

    // Randomized traffic on all channels.
    for (int t = 0; t < 800; t++) begin
      for (int ch = 0; ch < N; ch++) begin
        set_ng(ch, int'($urandom_range(10, 0)) - 3);
        set_nb(ch, int'($urandom_range(10, 0)) - 6);
        if ($urandom_range(15, 0) == 0) duration[ch*DB +: DB] = DB'($urandom_range(15, 0));
        if ($urandom_range(19, 0) == 0) clear_on_end[ch] = 1'($urandom_range(1, 0));
        if ($urandom_range(29, 0) == 0) begin
          good_tokens_threshold[ch*TB +: TB] = TB'($urandom_range(127, 0));
          bad_tokens_threshold[ch*TB +: TB]  = TB'($urandom_range(127, 0));
        end
      end
      tick  = 1'($urandom_range(1, 0));
      reset = ($urandom_range(59, 0) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
